// File: rtl/fare_collector.sv
// Fare collector front-end: coin accumulation, confirm/cancel handling and a registered hand-off to the ticket stage.
// Optional inactivity timeout in COLLECT is enabled with `define FARE_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | credit is zero, waiting for the first coin
// COLLECT | credit > 0, accepting coins, confirm or cancel
// COMMIT  | single cycle, transaction strobe is high
// WAIT    | ticket stage owns the transaction, outputs held until done
module fare_collector #(
    parameter int COIN0          = 5,
    parameter int COIN1          = 10,
    parameter int COIN2          = 20,
    parameter int COIN3          = 50,
    parameter int MAX_CREDIT     = 255,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       arstn,
    input  logic       coin_valid,
    input  logic [1:0] coin_code,
    input  logic [1:0] dest_sel,
    input  logic [1:0] ticket_req,
    input  logic       confirm,
    input  logic       cancel,
    input  logic       done,
    output logic [7:0] money,
    output logic [1:0] destination,
    output logic [1:0] ticket_count,
    output logic       transaction,
    output logic       coin_reject,
    output logic       refund_valid,
    output logic [7:0] refund_amt,
    output logic       busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_COMMIT, ST_WAIT} state_t;

    state_t     state, state_nxt;
    logic [7:0] money_nxt, refund_amt_nxt, coin_val;
    logic [1:0] dest_nxt, count_nxt;
    logic       trans_nxt, reject_nxt, refund_v_nxt, busy_nxt;
    logic [8:0] sum9;
    logic       fits, expire;

`ifdef FARE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer, timer_nxt;
`endif

    always_comb begin
        case (coin_code)
            2'd0:    coin_val = 8'(COIN0);
            2'd1:    coin_val = 8'(COIN1);
            2'd2:    coin_val = 8'(COIN2);
            default: coin_val = 8'(COIN3);
        endcase
    end

    assign sum9 = {1'b0, money} + {1'b0, coin_val};
    assign fits = sum9 <= 9'(MAX_CREDIT);

    always_comb begin
        state_nxt      = state;
        money_nxt      = money;
        dest_nxt       = destination;
        count_nxt      = ticket_count;
        trans_nxt      = 1'b0;
        reject_nxt     = 1'b0;
        refund_v_nxt   = 1'b0;
        refund_amt_nxt = 8'd0;
        expire         = 1'b0;
`ifdef FARE_TIMEOUT_EN
        timer_nxt      = timer;
        if (state == ST_COLLECT && !coin_valid && !confirm && !cancel) begin
            if (timer == '0) expire = 1'b1;
            else             timer_nxt = timer - 1'b1;
        end
`endif
        case (state)
            ST_IDLE: begin
                if (coin_valid) begin
                    if (fits) begin
                        money_nxt = sum9[7:0];
                        state_nxt = ST_COLLECT;
`ifdef FARE_TIMEOUT_EN
                        timer_nxt = TW'(TIMEOUT_CYCLES - 1);
`endif
                    end else begin
                        reject_nxt = 1'b1;
                    end
                end
            end
            ST_COLLECT: begin
                if (cancel || expire) begin
                    // a coin arriving with cancel is handed back, refund is pre-coin credit
                    reject_nxt     = coin_valid;
                    refund_v_nxt   = 1'b1;
                    refund_amt_nxt = money;
                    money_nxt      = 8'd0;
                    state_nxt      = ST_IDLE;
                end else if (coin_valid) begin
                    if (fits) begin
                        money_nxt = sum9[7:0];
`ifdef FARE_TIMEOUT_EN
                        timer_nxt = TW'(TIMEOUT_CYCLES - 1);
`endif
                    end else begin
                        reject_nxt = 1'b1;
                    end
                end else if (confirm) begin
                    dest_nxt  = dest_sel;
                    count_nxt = ticket_req;
                    trans_nxt = 1'b1;
                    state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                reject_nxt = coin_valid;
                state_nxt  = ST_WAIT;
            end
            default: begin
                reject_nxt = coin_valid;
                if (done) begin
                    money_nxt = 8'd0;
                    dest_nxt  = 2'd0;
                    count_nxt = 2'd0;
                    state_nxt = ST_IDLE;
                end
            end
        endcase
        busy_nxt = (state_nxt == ST_COMMIT) || (state_nxt == ST_WAIT);
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state        <= ST_IDLE;
            money        <= 8'd0;
            destination  <= 2'd0;
            ticket_count <= 2'd0;
            transaction  <= 1'b0;
            coin_reject  <= 1'b0;
            refund_valid <= 1'b0;
            refund_amt   <= 8'd0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            money        <= money_nxt;
            destination  <= dest_nxt;
            ticket_count <= count_nxt;
            transaction  <= trans_nxt;
            coin_reject  <= reject_nxt;
            refund_valid <= refund_v_nxt;
            refund_amt   <= refund_amt_nxt;
            busy         <= busy_nxt;
        end
    end

`ifdef FARE_TIMEOUT_EN
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) timer <= '0;
        else        timer <= timer_nxt;
    end
`endif

endmodule

// File: tb/tb_fare_collector.sv
// Directed table-driven bench for fare_collector, plus hand-written reset and timeout sequences.
module tb_fare_collector;

    logic       clk = 1'b0;
    logic       arstn;
    logic       coin_valid, confirm, cancel, done;
    logic [1:0] coin_code, dest_sel, ticket_req;
    logic [7:0] money, refund_amt;
    logic [1:0] destination, ticket_count;
    logic       transaction, coin_reject, refund_valid, busy;

    int checks = 0;
    int errors = 0;

    fare_collector #(.TIMEOUT_CYCLES(20)) dut (
        .clk(clk), .arstn(arstn),
        .coin_valid(coin_valid), .coin_code(coin_code),
        .dest_sel(dest_sel), .ticket_req(ticket_req),
        .confirm(confirm), .cancel(cancel), .done(done),
        .money(money), .destination(destination), .ticket_count(ticket_count),
        .transaction(transaction), .coin_reject(coin_reject),
        .refund_valid(refund_valid), .refund_amt(refund_amt), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       cv;
        logic [1:0] cc, ds, tr;
        logic       cf, cn, dn;
        logic [7:0] m;
        logic       t, rj, rv;
        logic [7:0] ra;
        logic       b;
        logic [1:0] d, c;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic cv, logic [1:0] cc, logic [1:0] ds, logic [1:0] tr,
                                logic cf, logic cn, logic dn, logic [7:0] m, logic t,
                                logic rj, logic rv, logic [7:0] ra, logic b,
                                logic [1:0] d, logic [1:0] c);
        vec_t v;
        v.cv = cv; v.cc = cc; v.ds = ds; v.tr = tr; v.cf = cf; v.cn = cn; v.dn = dn;
        v.m = m; v.t = t; v.rj = rj; v.rv = rv; v.ra = ra; v.b = b; v.d = d; v.c = c;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        coin_valid = 1'b0; coin_code = 2'd0; dest_sel = 2'd0; ticket_req = 2'd0;
        confirm = 1'b0; cancel = 1'b0; done = 1'b0;
    endtask

    task automatic chk_all(input string tag, input logic [7:0] m, input logic t, input logic rj,
                           input logic rv, input logic [7:0] ra, input logic b,
                           input logic [1:0] d, input logic [1:0] c);
        chk({tag, " money"}, 32'(money), 32'(m));
        chk({tag, " transaction"}, 32'(transaction), 32'(t));
        chk({tag, " coin_reject"}, 32'(coin_reject), 32'(rj));
        chk({tag, " refund_valid"}, 32'(refund_valid), 32'(rv));
        chk({tag, " refund_amt"}, 32'(refund_amt), 32'(ra));
        chk({tag, " busy"}, 32'(busy), 32'(b));
        chk({tag, " destination"}, 32'(destination), 32'(d));
        chk({tag, " ticket_count"}, 32'(ticket_count), 32'(c));
    endtask

    initial begin
        //                 cv cc    ds    tr    cf cn dn  money t  rj rv ra     b  d     c
        vecs.push_back(mk(1, 2'd1, 2'd0, 2'd0, 0, 0, 0, 8'd10,  0, 0, 0, 8'd0,  0, 2'd0, 2'd0));
        vecs.push_back(mk(1, 2'd2, 2'd0, 2'd0, 0, 0, 0, 8'd30,  0, 0, 0, 8'd0,  0, 2'd0, 2'd0));
        vecs.push_back(mk(1, 2'd3, 2'd0, 2'd0, 0, 0, 0, 8'd80,  0, 0, 0, 8'd0,  0, 2'd0, 2'd0));
        vecs.push_back(mk(0, 2'd0, 2'd2, 2'd3, 1, 0, 0, 8'd80,  1, 0, 0, 8'd0,  1, 2'd2, 2'd3));
        vecs.push_back(mk(0, 2'd0, 2'd1, 2'd1, 0, 0, 0, 8'd80,  0, 0, 0, 8'd0,  1, 2'd2, 2'd3));
        vecs.push_back(mk(1, 2'd3, 2'd0, 2'd0, 0, 1, 0, 8'd80,  0, 1, 0, 8'd0,  1, 2'd2, 2'd3));
        vecs.push_back(mk(0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 8'd80,  0, 0, 0, 8'd0,  1, 2'd2, 2'd3));
        vecs.push_back(mk(0, 2'd0, 2'd0, 2'd0, 0, 0, 1, 8'd0,   0, 0, 0, 8'd0,  0, 2'd0, 2'd0));
        vecs.push_back(mk(0, 2'd0, 2'd0, 2'd0, 0, 0, 1, 8'd0,   0, 0, 0, 8'd0,  0, 2'd0, 2'd0));
        vecs.push_back(mk(0, 2'd0, 2'd3, 2'd3, 1, 0, 0, 8'd0,   0, 0, 0, 8'd0,  0, 2'd0, 2'd0));
        // climb to 250, overflow reject, then exactly MAX_CREDIT
        vecs.push_back(mk(1, 2'd3, 2'd0, 2'd0, 0, 0, 0, 8'd50,  0, 0, 0, 8'd0,  0, 2'd0, 2'd0));
        vecs.push_back(mk(1, 2'd3, 2'd0, 2'd0, 0, 0, 0, 8'd100, 0, 0, 0, 8'd0,  0, 2'd0, 2'd0));
        vecs.push_back(mk(1, 2'd3, 2'd0, 2'd0, 0, 0, 0, 8'd150, 0, 0, 0, 8'd0,  0, 2'd0, 2'd0));
        vecs.push_back(mk(1, 2'd3, 2'd0, 2'd0, 0, 0, 0, 8'd200, 0, 0, 0, 8'd0,  0, 2'd0, 2'd0));
        vecs.push_back(mk(1, 2'd3, 2'd0, 2'd0, 0, 0, 0, 8'd250, 0, 0, 0, 8'd0,  0, 2'd0, 2'd0));
        vecs.push_back(mk(1, 2'd1, 2'd0, 2'd0, 0, 0, 0, 8'd250, 0, 1, 0, 8'd0,  0, 2'd0, 2'd0));
        vecs.push_back(mk(1, 2'd0, 2'd0, 2'd0, 0, 0, 0, 8'd255, 0, 0, 0, 8'd0,  0, 2'd0, 2'd0));
        vecs.push_back(mk(1, 2'd0, 2'd0, 2'd0, 0, 0, 0, 8'd255, 0, 1, 0, 8'd0,  0, 2'd0, 2'd0));
        vecs.push_back(mk(0, 2'd0, 2'd0, 2'd0, 0, 1, 0, 8'd0,   0, 0, 1, 8'd255,0, 2'd0, 2'd0));
        // credit 35, cancel with a coin
        vecs.push_back(mk(1, 2'd2, 2'd0, 2'd0, 0, 0, 0, 8'd20,  0, 0, 0, 8'd0,  0, 2'd0, 2'd0));
        vecs.push_back(mk(1, 2'd1, 2'd0, 2'd0, 0, 0, 0, 8'd30,  0, 0, 0, 8'd0,  0, 2'd0, 2'd0));
        vecs.push_back(mk(1, 2'd0, 2'd0, 2'd0, 0, 0, 0, 8'd35,  0, 0, 0, 8'd0,  0, 2'd0, 2'd0));
        vecs.push_back(mk(1, 2'd3, 2'd0, 2'd0, 0, 1, 0, 8'd0,   0, 1, 1, 8'd35, 0, 2'd0, 2'd0));
        vecs.push_back(mk(0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 8'd0,   0, 0, 0, 8'd0,  0, 2'd0, 2'd0));
        // coin with confirm drops the confirm; done during COMMIT is ignored
        vecs.push_back(mk(1, 2'd1, 2'd0, 2'd0, 0, 0, 0, 8'd10,  0, 0, 0, 8'd0,  0, 2'd0, 2'd0));
        vecs.push_back(mk(1, 2'd0, 2'd1, 2'd2, 1, 0, 0, 8'd15,  0, 0, 0, 8'd0,  0, 2'd0, 2'd0));
        vecs.push_back(mk(0, 2'd0, 2'd1, 2'd2, 1, 0, 0, 8'd15,  1, 0, 0, 8'd0,  1, 2'd1, 2'd2));
        vecs.push_back(mk(0, 2'd0, 2'd0, 2'd0, 0, 0, 1, 8'd15,  0, 0, 0, 8'd0,  1, 2'd1, 2'd2));
        vecs.push_back(mk(0, 2'd0, 2'd0, 2'd0, 0, 0, 1, 8'd0,   0, 0, 0, 8'd0,  0, 2'd0, 2'd0));

        idle_inputs();
        arstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 8'd0, 0, 0, 0, 8'd0, 0, 2'd0, 2'd0);
        #2 arstn = 1'b1;

        foreach (vecs[i]) begin
            coin_valid = vecs[i].cv; coin_code = vecs[i].cc;
            dest_sel = vecs[i].ds; ticket_req = vecs[i].tr;
            confirm = vecs[i].cf; cancel = vecs[i].cn; done = vecs[i].dn;
            tick();
            chk_all($sformatf("v%0d", i), vecs[i].m, vecs[i].t, vecs[i].rj, vecs[i].rv,
                    vecs[i].ra, vecs[i].b, vecs[i].d, vecs[i].c);
        end

        // asynchronous reset while collecting: credit lost, no refund
        idle_inputs();
        coin_valid = 1'b1; coin_code = 2'd2;
        tick();
        idle_inputs();
        chk("pre_rst money", 32'(money), 32'd20);
        #2 arstn = 1'b0;
        #1;
        chk_all("async_rst", 8'd0, 0, 0, 0, 8'd0, 0, 2'd0, 2'd0);
        #2 arstn = 1'b1;
        tick();
        chk_all("post_rst", 8'd0, 0, 0, 0, 8'd0, 0, 2'd0, 2'd0);
        confirm = 1'b1;
        tick();
        confirm = 1'b0;
        chk("post_rst confirm ignored", 32'(transaction), 32'd0);

        // inactivity in COLLECT with credit 5
        coin_valid = 1'b1; coin_code = 2'd0;
        tick();
        idle_inputs();
        chk("idle start money", 32'(money), 32'd5);
`ifdef FARE_TIMEOUT_EN
        repeat (19) tick();
        chk("timeout 19 money", 32'(money), 32'd5);
        chk("timeout 19 refund_valid", 32'(refund_valid), 32'd0);
        tick();
        chk("timeout refund_valid", 32'(refund_valid), 32'd1);
        chk("timeout refund_amt", 32'(refund_amt), 32'd5);
        chk("timeout money", 32'(money), 32'd0);
        tick();
        chk("timeout refund one cycle", 32'(refund_valid), 32'd0);
`else
        repeat (100) tick();
        chk("no timeout money", 32'(money), 32'd5);
        chk("no timeout refund_valid", 32'(refund_valid), 32'd0);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("late cancel refund_valid", 32'(refund_valid), 32'd1);
        chk("late cancel refund_amt", 32'(refund_amt), 32'd5);
        chk("late cancel money", 32'(money), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fare_collector.md
# fare_collector

Upstream front-end of the metro ticket machine: accumulates inserted coins into a running 8-bit credit, latches the rider's destination and ticket count on confirm, and presents money, destination, count and a one-cycle `transaction` strobe to the ticket-issuing stage. It holds those values stable until the downstream `done` pulse arrives. It returns credit on cancel, and it rejects any coin that would overflow the credit.

## Interface
- `COIN0`, default 5: value of coin code 0
- `COIN1`, default 10: value of coin code 1
- `COIN2`, default 20: value of coin code 2
- `COIN3`, default 50: value of coin code 3
- `MAX_CREDIT`, default 255: maximum accumulated credit, ≤255
- `TIMEOUT_CYCLES`, default 1000: inactivity limit, used only with `FARE_TIMEOUT_EN`
- `clk` in 1: single clock, rising edge
- `arstn` in 1: reset, asynchronous, active-low
- `coin_valid` in 1: one coin presented this cycle
- `coin_code` in 2: coin denomination select
- `dest_sel` in 2: rider destination selection
- `ticket_req` in 2: rider ticket count selection
- `confirm` in 1: rider confirm, level-sampled
- `cancel` in 1: rider cancel, level-sampled
- `done` in 1: downstream completion pulse
- `money` out 8: credit presented downstream
- `destination` out 2: latched destination
- `ticket_count` out 2: latched ticket count
- `transaction` out 1: one-cycle start strobe to the ticket stage
- `coin_reject` out 1: one-cycle pulse; the presented coin is returned
- `refund_valid` out 1: one-cycle pulse qualifying `refund_amt`
- `refund_amt` out 8: credit returned on cancel or timeout
- `busy` out 1: high in COMMIT and WAIT

## Operation
- Reset values: state IDLE; all outputs 0.
- States:
  - IDLE: credit 0.
  - COLLECT: credit > 0, accepting coins.
  - COMMIT: 1 cycle.
  - WAIT: downstream active.
- Coin accept, in IDLE or COLLECT:
  - If `credit + value ≤ MAX_CREDIT`: credit += value, and IDLE→COLLECT.
  - Otherwise: `coin_reject` pulses and credit is unchanged.
  - The sum is computed 9-bit, so no wrap.
- Coins in COMMIT or WAIT are always rejected with `coin_reject`.
- Confirm in COLLECT:
  - Latch `dest_sel` to `destination` and `ticket_req` to `ticket_count`.
  - Go to COMMIT.
- Confirm in IDLE (credit 0) is ignored.
- Cancel in COLLECT:
  - `refund_valid`=1 and `refund_amt`=credit for 1 cycle.
  - Credit cleared; go to IDLE.
- Cancel in COMMIT or WAIT is ignored, because the transaction is owned downstream.
- Same-cycle priority in COLLECT: cancel > coin > confirm.
  - Cancel with a coin: the coin is rejected and the refund is the pre-coin credit.
  - Coin with confirm: the coin is added and confirm is dropped, so the rider re-presses.
- COMMIT:
  - `transaction`=1 for exactly one cycle.
  - Unconditionally go to WAIT.
- WAIT:
  - `money`, `destination` and `ticket_count` are held constant.
  - On `done`=1, go to IDLE, clearing credit, `money`, `destination` and `ticket_count`.
  - Change and refund computation is downstream; this block never refunds in WAIT.
- `done` outside WAIT is ignored.
- `money` mirrors credit in every state.

## Timing
- Coin on cycle N: `money` updated at N+1; `coin_reject` asserted at N+1.
- Confirm sampled at N: state COMMIT and `transaction`=1 at N+1; WAIT at N+2.
- Cancel sampled at N: `refund_valid` at N+1, `money`=0 at N+1.
- `done` sampled at N in WAIT: IDLE and `money`=0 at N+1; a new coin is accepted from N+1.
- All outputs are registered; there are no combinational input-to-output paths.
- Reset asserted mid-WAIT or mid-COLLECT: immediate return to IDLE, credit lost, no refund pulse. System-level refund on power loss is out of scope.

## Configuration
- `FARE_TIMEOUT_EN` defined:
  - A counter reloads on every accepted coin and on entry to COLLECT.
  - In COLLECT, after `TIMEOUT_CYCLES` cycles with no coin, confirm or cancel, the block behaves exactly like cancel: refund pulse, then IDLE.
  - Confirm or cancel on the expiry cycle takes precedence over the timeout.
- `FARE_TIMEOUT_EN` undefined: no counter logic; COLLECT waits indefinitely.

## Test plan
- Reset, then coins 1, 2, 3 (10+20+50) then confirm → `money`=80, one `transaction` pulse, `destination`/`ticket_count` equal to inputs at confirm, `busy`=1.
- In WAIT: coin code 3 and cancel applied → `coin_reject` pulse, `money` stays 80, no refund; `done` pulse → `money`=0, IDLE, `busy`=0.
- Credit 250 plus coin code 1 (10) → `coin_reject`, `money`=250; then coin code 0 → `money`=255.
- Credit 35, cancel and coin the same cycle → `refund_amt`=35 with `refund_valid`, `coin_reject`=1, `money`=0.
- Coin and confirm the same cycle, then confirm alone → no `transaction` on the first cycle; `transaction` one cycle after the second confirm with the summed credit.
- With `FARE_TIMEOUT_EN` and `TIMEOUT_CYCLES`=20, credit 5, idle 20 cycles → refund 5 and IDLE. Without the macro, 100 idle cycles → still COLLECT, `money`=5.
